// File: rtl/nv_nvdla_cmac_core_done_ctrl_pkg.sv
// Shared CMAC done-control definitions: FSM encoding and drain-latency constants.
package nv_nvdla_cmac_core_done_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } cmac_done_st_e;

   localparam int unsigned DrainLatDefault = 7;
   localparam int unsigned WgExtraLat      = 2;

   // Wide enough for 31 - 1 + WgExtraLat.
   localparam int unsigned DrainCntW = 6;

endpackage

// File: rtl/nv_nvdla_cmac_core_done_ctrl_if.sv
// Handshake bundle between the MAC output pipeline / register file and the done controller.
interface nv_nvdla_cmac_core_done_ctrl_if #(
   parameter int unsigned CNT_W = 16
);

   logic             cfg_reg_en;
   logic             cfg_is_wg;
   logic             out_valid;
   logic             out_stripe_end;
   logic             out_layer_end;
   logic             err_clr;
   logic             dp2reg_done;
   logic             busy;
   logic [CNT_W-1:0] stripe_cnt;
   logic             err_unarmed;
   logic             err_rearm;

   modport master (
      output cfg_reg_en,
      output cfg_is_wg,
      output out_valid,
      output out_stripe_end,
      output out_layer_end,
      output err_clr,
      input  dp2reg_done,
      input  busy,
      input  stripe_cnt,
      input  err_unarmed,
      input  err_rearm
   );

   modport slave (
      input  cfg_reg_en,
      input  cfg_is_wg,
      input  out_valid,
      input  out_stripe_end,
      input  out_layer_end,
      input  err_clr,
      output dp2reg_done,
      output busy,
      output stripe_cnt,
      output err_unarmed,
      output err_rearm
   );

endinterface

// File: rtl/nv_nvdla_cmac_core_done_ctrl.sv
// Layer-done controller: counts stripes, waits out the MAC pipeline drain, then pulses done.
module nv_nvdla_cmac_core_done_ctrl
   import nv_nvdla_cmac_core_done_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_LAT = DrainLatDefault,
   parameter int unsigned CNT_W     = 16
) (
   input logic                          nvdla_core_clk,
   input logic                          nvdla_core_rstn,
   nv_nvdla_cmac_core_done_ctrl_if.slave bus
);

   localparam logic [DrainCntW-1:0] DrainLoadDirect = DrainCntW'(DRAIN_LAT - 1);
   localparam logic [DrainCntW-1:0] DrainLoadWg     = DrainCntW'(DRAIN_LAT - 1 + WgExtraLat);

   cmac_done_st_e        state_q, state_d;
   logic [DrainCntW-1:0] drain_q, drain_d;
   logic [CNT_W-1:0]     stripe_q, stripe_d;
   logic                 wg_q, wg_d;
   logic                 done_q, done_d;
   logic                 err_unarmed_q, err_unarmed_d;
   logic                 err_rearm_q, err_rearm_d;

   logic beat_stripe;
   logic beat_layer;
   logic set_unarmed;
   logic set_rearm;

   assign beat_stripe = bus.out_valid & bus.out_stripe_end;
   assign beat_layer  = bus.out_valid & bus.out_layer_end;

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      stripe_d = stripe_q;
      wg_d     = wg_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.cfg_reg_en) begin
               state_d  = StRun;
               stripe_d = '0;
               wg_d     = bus.cfg_is_wg;
            end
         end
         StRun: begin
            if (beat_stripe && (stripe_q != '1)) begin
               stripe_d = stripe_q + CNT_W'(1);
            end
            if (beat_layer) begin
               state_d = StDrain;
               drain_d = wg_q ? DrainLoadWg : DrainLoadDirect;
            end
         end
         StDrain: begin
            if (drain_q == '0) begin
               state_d = StDone;
               // Registered so the done pulse is a pure flop output.
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q - DrainCntW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      set_unarmed = beat_layer && (state_q != StRun);
      set_rearm   = (bus.cfg_reg_en && (state_q != StIdle)) ||
                    (bus.out_valid && ((state_q == StDrain) || (state_q == StDone)));
      // A same-cycle set beats the clear.
      err_unarmed_d = set_unarmed | (err_unarmed_q & ~bus.err_clr);
      err_rearm_d   = set_rearm   | (err_rearm_q   & ~bus.err_clr);
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q       <= StIdle;
         drain_q       <= '0;
         stripe_q      <= '0;
         wg_q          <= 1'b0;
         done_q        <= 1'b0;
         err_unarmed_q <= 1'b0;
         err_rearm_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         drain_q       <= drain_d;
         stripe_q      <= stripe_d;
         wg_q          <= wg_d;
         done_q        <= done_d;
         err_unarmed_q <= err_unarmed_d;
         err_rearm_q   <= err_rearm_d;
      end
   end

   assign bus.dp2reg_done = done_q;
   assign bus.busy        = (state_q != StIdle);
   assign bus.stripe_cnt  = stripe_q;
   assign bus.err_unarmed = err_unarmed_q;
   assign bus.err_rearm   = err_rearm_q;

endmodule

// File: tb/tb_nv_nvdla_cmac_core_done_ctrl.sv
// Scoreboard bench for the CMAC done controller; a CNT_W=4 copy shares the stimulus.
module tb_nv_nvdla_cmac_core_done_ctrl;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      int cyc;
      int stripes;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   nv_nvdla_cmac_core_done_ctrl_if #(.CNT_W(16)) a ();
   nv_nvdla_cmac_core_done_ctrl_if #(.CNT_W(4))  b ();

   nv_nvdla_cmac_core_done_ctrl #(.DRAIN_LAT(7), .CNT_W(16)) u_dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .bus             (a)
   );

   nv_nvdla_cmac_core_done_ctrl #(.DRAIN_LAT(7), .CNT_W(4)) u_dut_sat (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .bus             (b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
      end
   endtask

   // Every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rstn && (a.dp2reg_done === 1'b1)) begin
         check("done_pending", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("done_stripes", 32'(a.stripe_cnt), 32'(e.stripes));
         end
      end
   end

   task automatic drive(input bit en, input bit wg, input bit v, input bit se, input bit le,
                        input bit clr);
      @(negedge clk);
      a.cfg_reg_en = en;  b.cfg_reg_en = en;
      a.cfg_is_wg = wg;   b.cfg_is_wg = wg;
      a.out_valid = v;    b.out_valid = v;
      a.out_stripe_end = se;  b.out_stripe_end = se;
      a.out_layer_end = le;   b.out_layer_end = le;
      a.err_clr = clr;    b.err_clr = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic arm(input bit wg);
      drive(1'b1, wg, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic stripe_beat();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic layer_end(input bit se, input int lat, input int stripes, input bit expect_done,
                            output int t);
      drive(1'b0, 1'b0, 1'b1, se, 1'b1, 1'b0);
      t = cyc;
      if (expect_done) sb.push_back('{t + lat, stripes});
   endtask

   task automatic run_to(input int target);
      while (cyc < target) idle(1);
   endtask

   task automatic clear_errs();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int t;
      a.cfg_reg_en = 0; a.cfg_is_wg = 0; a.out_valid = 0;
      a.out_stripe_end = 0; a.out_layer_end = 0; a.err_clr = 0;
      b.cfg_reg_en = 0; b.cfg_is_wg = 0; b.out_valid = 0;
      b.out_stripe_end = 0; b.out_layer_end = 0; b.err_clr = 0;
      repeat (3) @(negedge clk);
      check("rst_done", 32'(a.dp2reg_done), 32'd0);
      check("rst_busy", 32'(a.busy), 32'd0);
      check("rst_stripe", 32'(a.stripe_cnt), 32'd0);
      check("rst_err_unarmed", 32'(a.err_unarmed), 32'd0);
      check("rst_err_rearm", 32'(a.err_rearm), 32'd0);
      check("rst_stripe_sat", 32'(b.stripe_cnt), 32'd0);
      rstn = 1'b1;
      idle(2);

      // Plain layer: 3 stripes plus a stripe on the layer-end beat.
      arm(1'b0);
      repeat (3) stripe_beat();
      layer_end(1'b1, 8, 4, 1'b1, t);
      run_to(t + 8);
      check("busy_in_done", 32'(a.busy), 32'd1);
      run_to(t + 9);
      check("busy_after_done", 32'(a.busy), 32'd0);
      check("stripe_after_done", 32'(a.stripe_cnt), 32'd4);
      check("no_err_unarmed", 32'(a.err_unarmed), 32'd0);
      check("no_err_rearm", 32'(a.err_rearm), 32'd0);
      idle(3);
      check("stripe_hold", 32'(a.stripe_cnt), 32'd4);

      // Winograd layer then a direct layer.
      arm(1'b1);
      idle(1);
      check("arm_clears_stripe", 32'(a.stripe_cnt), 32'd0);
      check("busy_in_run", 32'(a.busy), 32'd1);
      stripe_beat();
      layer_end(1'b0, 10, 1, 1'b1, t);
      run_to(t + 12);
      arm(1'b0);
      layer_end(1'b0, 8, 0, 1'b1, t);
      run_to(t + 10);

      // Saturation on the narrow counter.
      arm(1'b0);
      repeat (20) stripe_beat();
      idle(1);
      check("stripe_20", 32'(a.stripe_cnt), 32'd20);
      check("stripe_sat_15", 32'(b.stripe_cnt), 32'd15);
      layer_end(1'b0, 8, 20, 1'b1, t);
      run_to(t + 10);
      check("stripe_sat_hold", 32'(b.stripe_cnt), 32'd15);

      // Layer end while idle.
      layer_end(1'b0, 8, 0, 1'b0, t);
      idle(1);
      check("idle_le_err_unarmed", 32'(a.err_unarmed), 32'd1);
      check("idle_le_err_rearm", 32'(a.err_rearm), 32'd0);
      check("idle_le_busy", 32'(a.busy), 32'd0);
      check("idle_le_stripe", 32'(a.stripe_cnt), 32'd20);
      idle(12);
      clear_errs();
      check("clr_err_unarmed", 32'(a.err_unarmed), 32'd0);

      // Re-arm during drain is ignored and leaves the done timing alone.
      arm(1'b0);
      layer_end(1'b0, 8, 0, 1'b1, t);
      idle(2);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("drain_arm_err_rearm", 32'(a.err_rearm), 32'd1);
      check("drain_arm_err_unarmed", 32'(a.err_unarmed), 32'd0);
      run_to(t + 10);
      check("drain_arm_ignored", 32'(a.busy), 32'd0);
      clear_errs();
      check("clr_err_rearm", 32'(a.err_rearm), 32'd0);

      // Set beats clear in the same cycle.
      arm(1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      check("set_wins_clear", 32'(a.err_rearm), 32'd1);
      layer_end(1'b0, 8, 0, 1'b1, t);
      run_to(t + 10);
      clear_errs();

      // Arm and layer end together in idle: arm taken, beat dropped.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("arm_le_busy", 32'(a.busy), 32'd1);
      check("arm_le_err_unarmed", 32'(a.err_unarmed), 32'd1);
      idle(10);
      check("arm_le_still_run", 32'(a.busy), 32'd1);
      layer_end(1'b0, 8, 0, 1'b1, t);
      run_to(t + 10);
      clear_errs();

      // Reset three cycles into drain aborts the layer.
      arm(1'b0);
      stripe_beat();
      layer_end(1'b0, 8, 1, 1'b0, t);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_to(t + 3);
      check("drain_valid_err_rearm", 32'(a.err_rearm), 32'd1);
      check("drain_busy", 32'(a.busy), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("abort_done", 32'(a.dp2reg_done), 32'd0);
      check("abort_busy", 32'(a.busy), 32'd0);
      check("abort_stripe", 32'(a.stripe_cnt), 32'd0);
      check("abort_err_unarmed", 32'(a.err_unarmed), 32'd0);
      check("abort_err_rearm", 32'(a.err_rearm), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      idle(20);
      check("post_abort_busy", 32'(a.busy), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nv_nvdla_cmac_core_done_ctrl.md
NV_NVDLA_CMAC_CORE_DONE_CTRL -- requirements
Module: NV_NVDLA_CMAC_CORE_done_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_LAT, default 7: cycles of MAC output-pipeline drain after the layer-end beat; legal range 1..31.
REQ-002 SHALL have parameter CNT_W, default 16: stripe counter width.
REQ-003 SHALL have port nvdla_core_clk  input  1  the single core clock; all state is rising-edge.
REQ-004 SHALL have port nvdla_core_rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_reg_en  input  1  one-cycle arm pulse for a new layer.
REQ-006 SHALL have port cfg_is_wg  input  1  winograd mode; sampled only when cfg_reg_en is high.
REQ-007 SHALL have port out_valid  input  1  MAC output beat valid.
REQ-008 SHALL have port out_stripe_end  input  1  beat closes a stripe; qualified by out_valid.
REQ-009 SHALL have port out_layer_end  input  1  beat closes the layer; qualified by out_valid.
REQ-010 SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-011 SHALL have port dp2reg_done  output  1  one-cycle layer-done pulse.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port stripe_cnt  output  CNT_W  stripes completed in the current or last layer.
REQ-014 SHALL have port err_unarmed  output  1  sticky: layer_end seen while not in RUN.
REQ-015 SHALL have port err_rearm  output  1  sticky: cfg_reg_en seen while not in IDLE, or out_valid seen in DRAIN/DONE.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: cfg_reg_en -> RUN; clear stripe_cnt; latch wg_q = cfg_is_wg.
REQ-018 RUN: out_valid & out_stripe_end -> stripe_cnt + 1, saturating at all-ones with no wrap.
REQ-019 RUN: out_valid & out_layer_end -> DRAIN; load drain_cnt = DRAIN_LAT - 1 + (wg_q ? 2 : 0). A stripe_end on the same beat still counts.
REQ-020 DRAIN: drain_cnt decrements by 1 each cycle; at drain_cnt == 0 the next state is DONE.
REQ-021 DONE: dp2reg_done = 1 for exactly this cycle; next state is IDLE.
REQ-022 Latency: a layer_end beat in cycle T SHALL produce dp2reg_done in cycle T+DRAIN_LAT+1, or T+DRAIN_LAT+3 when wg_q is set.
REQ-023 dp2reg_done SHALL be a flop output with no combinational path from any input.
REQ-024 out_valid & out_layer_end in IDLE, DRAIN or DONE SHALL set err_unarmed, be otherwise ignored, and leave stripe_cnt unchanged.
REQ-025 out_valid in DRAIN or DONE SHALL set err_rearm.
REQ-026 cfg_reg_en in RUN, DRAIN or DONE SHALL set err_rearm and be ignored; wg_q is unchanged.
REQ-027 cfg_reg_en together with out_layer_end in IDLE: the arm is taken, the beat is ignored, and err_unarmed is set.
REQ-028 err_clr SHALL clear both flags next cycle; a same-cycle set wins over the clear.
REQ-029 stripe_cnt SHALL hold its value after DONE until the next arm.

Reset
REQ-030 On nvdla_core_rstn low, the block SHALL asynchronously go to IDLE with dp2reg_done = 0, busy = 0, stripe_cnt = 0, err_unarmed = 0, err_rearm = 0, wg_q = 0, drain_cnt = 0.
REQ-031 Reset asserted mid-layer, in any state, SHALL abort the layer with no dp2reg_done pulse; release takes effect on a clock edge.

Structure
REQ-032 A shared CMAC package SHALL hold the FSM state encoding, the DRAIN_LAT default, and WG_EXTRA_LAT = 2.
REQ-033 The block SHALL be a single module with no sub-module; the counters are inline.

Verification
REQ-034 Arm (wg=0), 3 stripe_end beats, then a layer_end beat at cycle T -> stripe_cnt=4, dp2reg_done high only at T+8, busy low from T+9.
REQ-035 Arm with cfg_is_wg=1, layer_end at T -> dp2reg_done at T+10; a second layer armed with wg=0 -> dp2reg_done at T'+8.
REQ-036 With CNT_W=4, drive 20 stripe_end beats -> stripe_cnt holds at 15.
REQ-037 layer_end while IDLE -> err_unarmed=1, no done pulse; cfg_reg_en during DRAIN -> err_rearm=1 and done timing unchanged; err_clr -> both flags 0.
REQ-038 Assert reset 3 cycles into DRAIN -> all outputs 0 immediately, no dp2reg_done after release, busy=0.
